ofdm_dac_sample_buffer: RTL and testbench

OFDM_DAC_SAMPLE_BUFFER -- requirements
Module: ofdm_dac_sample_buffer

---
 rtl/ofdm_bbp_pkg.sv | 21 ++
 rtl/ofdm_sync_fifo.sv | 74 +++++++
 rtl/ofdm_dac_sample_buffer.sv | 159 +++++++++++++++
 tb/tb_ofdm_dac_sample_buffer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ofdm_bbp_pkg.sv
// ---------------------------------------------------------------------------
// ofdm_bbp_pkg
// Shared definitions for the OFDM baseband DAC path.
//   buf_state_e : sample-buffer playout FSM states (IDLE, PREFILL, RUN)
//   sample_w()  : packed width of one multi-channel I/Q sample word
// ---------------------------------------------------------------------------
package ofdm_bbp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PREFILL = 2'd1,
      ST_RUN     = 2'd2
   } buf_state_e;

   // One sample word carries {Q,I} per channel, channels packed LSB first.
   function automatic int unsigned sample_w(input int unsigned num_ch,
                                            input int unsigned data_w);
      return num_ch * 2 * data_w;
   endfunction

endpackage

// File: rtl/ofdm_sync_fifo.sv
// ---------------------------------------------------------------------------
// ofdm_sync_fifo
// Single-clock FIFO holding storage, read/write pointers and occupancy.
//   clk, rst : clock, asynchronous active-high reset (pointers/level only)
//   flush    : synchronous clear of pointers and level, overrides push/pop
//   push     : write wr_data (caller guarantees not full)
//   pop      : advance read pointer (caller guarantees not empty)
//   rd_data  : entry at the read pointer (combinational read)
//   level    : current occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by natural overflow.
// ---------------------------------------------------------------------------
module ofdm_sync_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   // Storage has no reset; an entry is only ever read after being written.
   logic [WIDTH-1:0] mem_q [DEPTH];

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q,  level_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem_q[wr_ptr_q] <= wr_data;
   end

   assign rd_data = mem_q[rd_ptr_q];
   assign level   = level_q;

endmodule

// File: rtl/ofdm_dac_sample_buffer.sv
// ---------------------------------------------------------------------------
// ofdm_dac_sample_buffer
// Elastic buffer between the OFDM sample producer and the DAC interface.
// Samples are prefilled up to PREFILL entries, then popped one per DAC
// strobe into a registered output. Underflow and overflow are sticky.
//   clk, rst   : DAC clock, asynchronous active-high reset
//   enable     : playout enable; low flushes the FIFO and returns to IDLE
//   clr_flags  : pulse clearing dac_dunf/dac_dovf (a coincident set wins)
//   s_valid/s_ready/s_data : producer handshake, {Q,I} per channel
//   dac_valid  : DAC sample strobe
//   dac_data   : registered DAC sample word
//   dac_dunf   : sticky underflow (strobe in RUN with empty FIFO)
//   dac_dovf   : sticky overflow (s_valid while enabled and full)
//   level      : FIFO occupancy
//   running    : high in RUN
// Build option: OFDM_DAC_HOLD_LAST_EN -- underflow repeats the last output
// word instead of emitting zeros. Flags and FSM are unaffected.
// ---------------------------------------------------------------------------
module ofdm_dac_sample_buffer
   import ofdm_bbp_pkg::*;
#(
   parameter int unsigned NUM_CH  = 1,
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned PREFILL = 8
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  enable,
   input  logic                                  clr_flags,
   input  logic                                  s_valid,
   output logic                                  s_ready,
   input  logic [sample_w(NUM_CH, DATA_W)-1:0]   s_data,
   input  logic                                  dac_valid,
   output logic [sample_w(NUM_CH, DATA_W)-1:0]   dac_data,
   output logic                                  dac_dunf,
   output logic                                  dac_dovf,
   output logic [$clog2(DEPTH):0]                level,
   output logic                                  running
);

   localparam int unsigned SW = sample_w(NUM_CH, DATA_W);
   localparam int unsigned LW = $clog2(DEPTH) + 1;
   localparam logic [LW-1:0] FULL_LVL    = LW'(DEPTH);
   localparam logic [LW-1:0] PREFILL_LVL = LW'(PREFILL);

   buf_state_e state_q, state_d;

   logic [SW-1:0] dac_data_q, dac_data_d;
   logic          dunf_q, dunf_d;
   logic          dovf_q, dovf_d;

   logic [SW-1:0] fifo_rd_data;
   logic [LW-1:0] fifo_level;
   logic          full;
   logic          push;
   logic          pop;
   logic          strobe_run;
   logic          underflow;
   logic          flush;
   logic [SW-1:0] uf_value;

   // ------------------------------------------------------------------
   // FIFO control
   // ------------------------------------------------------------------
   assign full    = (fifo_level == FULL_LVL);
   // Readiness uses the pre-pop level, so a full FIFO refuses a push even
   // when a pop happens on the same edge. Held low throughout reset.
   assign s_ready = enable && !full && !rst;
   assign push    = s_valid && s_ready;
   assign flush   = !enable;

   // A strobe only consumes in RUN; the empty check uses the registered
   // level, so a same-cycle push never rescues an underflow.
   assign strobe_run = enable && (state_q == ST_RUN) && dac_valid;
   assign pop        = strobe_run && (fifo_level != '0);
   assign underflow  = strobe_run && (fifo_level == '0);

   ofdm_sync_fifo #(
      .WIDTH (SW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .push    (push),
      .wr_data (s_data),
      .pop     (pop),
      .rd_data (fifo_rd_data),
      .level   (fifo_level)
   );

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      if (!enable) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:    state_d = ST_PREFILL;
            ST_PREFILL: if (fifo_level >= PREFILL_LVL) state_d = ST_RUN;
            ST_RUN:     if (underflow) state_d = ST_PREFILL;
            default:    state_d = ST_IDLE;
         endcase
      end
   end

   // FSM: outputs
   always_comb begin
      running = 1'b0;
      if (state_q == ST_RUN) running = 1'b1;
   end

   // ------------------------------------------------------------------
   // Output register and sticky flags
   // ------------------------------------------------------------------
`ifdef OFDM_DAC_HOLD_LAST_EN
   assign uf_value = dac_data_q;
`else
   assign uf_value = '0;
`endif

   always_comb begin
      dac_data_d = dac_data_q;
      if (!enable)        dac_data_d = '0;
      else if (pop)       dac_data_d = fifo_rd_data;
      else if (underflow) dac_data_d = uf_value;

      // Set has priority over clear.
      dunf_d = underflow | (dunf_q & ~clr_flags);
      dovf_d = (s_valid & enable & full) | (dovf_q & ~clr_flags);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dac_data_q <= '0;
         dunf_q     <= 1'b0;
         dovf_q     <= 1'b0;
      end else begin
         dac_data_q <= dac_data_d;
         dunf_q     <= dunf_d;
         dovf_q     <= dovf_d;
      end
   end

   assign dac_data = dac_data_q;
   assign dac_dunf = dunf_q;
   assign dac_dovf = dovf_q;
   assign level    = fifo_level;

endmodule

// File: tb/tb_ofdm_dac_sample_buffer.sv
module tb_ofdm_dac_sample_buffer;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Default-configuration instance
   logic        enable, clr_flags, s_valid, dac_valid;
   logic        s_ready, dac_dunf, dac_dovf, running;
   logic [31:0] s_data, dac_data;
   logic [4:0]  level;

   // Four-channel, 12-bit instance
   logic        enable_w, clr_flags_w, s_valid_w, dac_valid_w;
   logic        s_ready_w, dac_dunf_w, dac_dovf_w, running_w;
   logic [95:0] s_data_w, dac_data_w;
   logic [4:0]  level_w;

   int n_cmp = 0;
   int n_bad = 0;

   ofdm_dac_sample_buffer #(
      .NUM_CH(1), .DATA_W(16), .DEPTH(16), .PREFILL(8)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .clr_flags(clr_flags),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .dac_valid(dac_valid), .dac_data(dac_data), .dac_dunf(dac_dunf),
      .dac_dovf(dac_dovf), .level(level), .running(running)
   );

   ofdm_dac_sample_buffer #(
      .NUM_CH(4), .DATA_W(12), .DEPTH(16), .PREFILL(1)
   ) dut_w (
      .clk(clk), .rst(rst), .enable(enable_w), .clr_flags(clr_flags_w),
      .s_valid(s_valid_w), .s_ready(s_ready_w), .s_data(s_data_w),
      .dac_valid(dac_valid_w), .dac_data(dac_data_w), .dac_dunf(dac_dunf_w),
      .dac_dovf(dac_dovf_w), .level(level_w), .running(running_w)
   );

   // Sample k: I = k, Q = -k (16-bit two's complement)
   function automatic logic [31:0] smp(input int k);
      logic [15:0] i, q;
      i = 16'(k);
      q = 16'(-k);
      return {q, i};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_seq(input int n, input int base);
      for (int i = 0; i < n; i++) begin
         s_valid = 1'b1;
         s_data  = smp(base + i);
         tick();
      end
      s_valid = 1'b0;
   endtask

   task automatic do_flush();
      enable = 1'b0;
      tick();
      enable = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      enable = 1'b0; clr_flags = 1'b0; s_valid = 1'b0; dac_valid = 1'b0; s_data = '0;
      enable_w = 1'b0; clr_flags_w = 1'b0; s_valid_w = 1'b0; dac_valid_w = 1'b0; s_data_w = '0;
      tick();
      tick();
      n_cmp++; if (level !== 5'd0) begin n_bad++; $display("FAIL reset_level: got %0d expected 0", level); end
      n_cmp++; if (dac_data !== 32'h0) begin n_bad++; $display("FAIL reset_dac_data: got %h expected 0", dac_data); end
      n_cmp++; if (dac_dunf !== 1'b0 || dac_dovf !== 1'b0) begin n_bad++; $display("FAIL reset_flags: got dunf=%b dovf=%b expected 0 0", dac_dunf, dac_dovf); end
      n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL reset_running: got %b expected 0", running); end
      n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL reset_s_ready: got %b expected 0", s_ready); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_prefill_run();
      enable = 1'b1;
      tick();                       // IDLE -> PREFILL
      push_seq(8, 0);
      n_cmp++; if (level !== 5'd8) begin n_bad++; $display("FAIL prefill_level: got %0d expected 8", level); end
      n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL prefill_not_running: got %b expected 0", running); end
      tick();                       // registered level seen -> RUN
      n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL run_rise: got %b expected 1", running); end
      for (int k = 0; k < 8; k++) begin
         dac_valid = 1'b1;
         tick();
         dac_valid = 1'b0;
         n_cmp++; if (dac_data !== smp(k)) begin n_bad++; $display("FAIL run_data[%0d]: got %h expected %h", k, dac_data, smp(k)); end
         tick();
         n_cmp++; if (dac_data !== smp(k)) begin n_bad++; $display("FAIL run_hold[%0d]: got %h expected %h", k, dac_data, smp(k)); end
      end
      n_cmp++; if (level !== 5'd0) begin n_bad++; $display("FAIL run_drained: got %0d expected 0", level); end
      n_cmp++; if (dac_dunf !== 1'b0 || dac_dovf !== 1'b0) begin n_bad++; $display("FAIL run_no_flags: got dunf=%b dovf=%b expected 0 0", dac_dunf, dac_dovf); end
   endtask

   task automatic test_underflow();
      logic [31:0] exp_uf;
`ifdef OFDM_DAC_HOLD_LAST_EN
      exp_uf = smp(7);
`else
      exp_uf = 32'h0;
`endif
      do_flush();
      n_cmp++; if (dac_data !== 32'h0) begin n_bad++; $display("FAIL uf_flush_data: got %h expected 0", dac_data); end
      push_seq(8, 0);
      tick();
      for (int k = 0; k < 8; k++) begin
         dac_valid = 1'b1;
         tick();
         dac_valid = 1'b0;
         tick();
      end
      n_cmp++; if (dac_data !== smp(7)) begin n_bad++; $display("FAIL uf_last_data: got %h expected %h", dac_data, smp(7)); end
      n_cmp++; if (dac_dunf !== 1'b0) begin n_bad++; $display("FAIL uf_before: got %b expected 0", dac_dunf); end
      dac_valid = 1'b1;
      tick();
      dac_valid = 1'b0;
      n_cmp++; if (dac_dunf !== 1'b1) begin n_bad++; $display("FAIL uf_flag: got %b expected 1", dac_dunf); end
      n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL uf_back_to_prefill: got %b expected 0", running); end
      n_cmp++; if (dac_data !== exp_uf) begin n_bad++; $display("FAIL uf_value: got %h expected %h", dac_data, exp_uf); end
      clr_flags = 1'b1;
      tick();
      clr_flags = 1'b0;
      n_cmp++; if (dac_dunf !== 1'b0) begin n_bad++; $display("FAIL uf_clear: got %b expected 0", dac_dunf); end
   endtask

   task automatic test_overflow();
      do_flush();
      for (int i = 0; i < 16; i++) begin
         n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL ovf_ready[%0d]: got %b expected 1", i, s_ready); end
         s_valid = 1'b1;
         s_data  = smp(100 + i);
         tick();
      end
      s_valid = 1'b0;
      n_cmp++; if (level !== 5'd16) begin n_bad++; $display("FAIL ovf_full_level: got %0d expected 16", level); end
      n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL ovf_ready_low: got %b expected 0", s_ready); end
      n_cmp++; if (dac_dovf !== 1'b0) begin n_bad++; $display("FAIL ovf_early: got %b expected 0", dac_dovf); end
      s_valid = 1'b1;
      s_data  = smp(999);
      tick();
      s_valid = 1'b0;
      n_cmp++; if (dac_dovf !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %b expected 1", dac_dovf); end
      n_cmp++; if (level !== 5'd16) begin n_bad++; $display("FAIL ovf_level_hold: got %0d expected 16", level); end
   endtask

   task automatic test_full_pop();
      // FSM is in RUN here (prefill crossed during the overflow fill).
      n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL fp_running: got %b expected 1", running); end
      s_valid = 1'b1; s_data = smp(200); dac_valid = 1'b1;
      tick();
      s_valid = 1'b0; dac_valid = 1'b0;
      n_cmp++; if (level !== 5'd15) begin n_bad++; $display("FAIL fp_level_15: got %0d expected 15", level); end
      n_cmp++; if (dac_data !== smp(100)) begin n_bad++; $display("FAIL fp_pop_data: got %h expected %h", dac_data, smp(100)); end
      s_valid = 1'b1; s_data = smp(201);
      tick();
      s_valid = 1'b0;
      n_cmp++; if (level !== 5'd16) begin n_bad++; $display("FAIL fp_level_16: got %0d expected 16", level); end
      dac_valid = 1'b1;
      tick();
      dac_valid = 1'b0;
      n_cmp++; if (dac_data !== smp(101)) begin n_bad++; $display("FAIL fp_refused_absent: got %h expected %h", dac_data, smp(101)); end
   endtask

   task automatic test_enable_drop();
      enable = 1'b0;
      tick();
      n_cmp++; if (level !== 5'd0) begin n_bad++; $display("FAIL en_level: got %0d expected 0", level); end
      n_cmp++; if (dac_data !== 32'h0) begin n_bad++; $display("FAIL en_data: got %h expected 0", dac_data); end
      n_cmp++; if (running !== 1'b0 || s_ready !== 1'b0) begin n_bad++; $display("FAIL en_idle: got running=%b s_ready=%b expected 0 0", running, s_ready); end
      enable = 1'b1;
      tick();
      n_cmp++; if (running !== 1'b0 || s_ready !== 1'b1) begin n_bad++; $display("FAIL en_prefill: got running=%b s_ready=%b expected 0 1", running, s_ready); end
      push_seq(8, 300);
      tick();
      n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL en_rerun: got %b expected 1", running); end
      dac_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         n_cmp++; if (dac_data !== smp(300 + i)) begin n_bad++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, dac_data, smp(300 + i)); end
      end
      n_cmp++; if (dac_dovf !== 1'b1 || dac_dunf !== 1'b0) begin n_bad++; $display("FAIL clr_pre: got dovf=%b dunf=%b expected 1 0", dac_dovf, dac_dunf); end
      clr_flags = 1'b1;             // coincides with the underflow strobe
      tick();
      clr_flags = 1'b0; dac_valid = 1'b0;
      n_cmp++; if (dac_dunf !== 1'b1) begin n_bad++; $display("FAIL clr_set_wins: got %b expected 1", dac_dunf); end
      n_cmp++; if (dac_dovf !== 1'b0) begin n_bad++; $display("FAIL clr_dovf: got %b expected 0", dac_dovf); end
   endtask

   task automatic test_lanes();
      logic [11:0] lane [8];
      for (int j = 0; j < 8; j++) begin
         lane[j] = 12'h3C0 + 12'(j * 17);
         s_data_w[j*12 +: 12] = lane[j];
      end
      enable_w = 1'b1;
      tick();
      s_valid_w = 1'b1;
      tick();
      s_valid_w = 1'b0;
      n_cmp++; if (level_w !== 5'd1) begin n_bad++; $display("FAIL lane_level: got %0d expected 1", level_w); end
      n_cmp++; if (dac_data_w !== 96'h0) begin n_bad++; $display("FAIL lane_pre_data: got %h expected 0", dac_data_w); end
      tick();
      dac_valid_w = 1'b1;
      tick();
      dac_valid_w = 1'b0;
      for (int j = 0; j < 8; j++) begin
         n_cmp++; if (dac_data_w[j*12 +: 12] !== lane[j]) begin n_bad++; $display("FAIL lane[%0d]: got %h expected %h", j, dac_data_w[j*12 +: 12], lane[j]); end
      end
      n_cmp++; if (level_w !== 5'd0 || dac_dunf_w !== 1'b0) begin n_bad++; $display("FAIL lane_after: got level=%0d dunf=%b expected 0 0", level_w, dac_dunf_w); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_prefill_run();
      test_underflow();
      test_overflow();
      test_full_pop();
      test_enable_drop();
      test_lanes();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
